// File: rtl/fgba_pkg.sv
// Shared definitions for the memory subsystem: access width encodings and
// the arbiter state encoding.
package fgba_pkg;

    localparam logic [1:0] W_BYTE    = 2'd0;
    localparam logic [1:0] W_HALF    = 2'd1;
    localparam logic [1:0] W_WORD    = 2'd2;
    localparam logic [1:0] W_ILLEGAL = 2'd3;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Cycle counter that flags an access the memory has not acknowledged within
// TIMEOUT cycles; saturates at the expiry value until cleared.
module mem_arb_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [7:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && !expire) begin
            count_reg <= count_reg + 8'd1;
        end
    end

    assign expire = (count_reg == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing the system memory port between CPU (port 0) and
// DMA/graphics (port 1). Define MEM_ARB_ROUND_ROBIN_EN for round-robin ties.
module mem_arbiter
    import fgba_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int AW      = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p0_req,
    input  logic [AW-1:0] p0_addr,
    input  logic [31:0]   p0_wdata,
    input  logic [1:0]    p0_width,
    input  logic          p0_write,
    output logic          p0_ok,
    output logic          p0_err,
    output logic [31:0]   p0_rdata,
    input  logic          p1_req,
    input  logic [AW-1:0] p1_addr,
    input  logic [31:0]   p1_wdata,
    input  logic [1:0]    p1_width,
    input  logic          p1_write,
    output logic          p1_ok,
    output logic          p1_err,
    output logic [31:0]   p1_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [1:0]    mem_width,
    output logic          mem_read,
    output logic          mem_write,
    input  logic [31:0]   mem_rdata,
    input  logic          mem_ok
);

    localparam logic [1:0] S_IDLE = ARB_IDLE;
    localparam logic [1:0] S_BUSY = ARB_BUSY;
    localparam logic [1:0] S_DONE = ARB_DONE;

    logic [1:0]    state_reg;
    logic          port_reg;
    logic          write_reg;
    logic          last_grant_reg;

    logic          grant_valid;
    logic          grant_port;
    logic [AW-1:0] sel_addr;
    logic [31:0]   sel_wdata;
    logic [1:0]    sel_width;
    logic          sel_write;
    logic          wd_expire;

    always_comb begin
        grant_valid = p0_req | p1_req;
        grant_port  = p1_req;
        if (p0_req && p1_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            grant_port = ~last_grant_reg;
`else
            grant_port = 1'b1 | last_grant_reg;
`endif
        end
        sel_addr  = grant_port ? p1_addr  : p0_addr;
        sel_wdata = grant_port ? p1_wdata : p0_wdata;
        sel_width = grant_port ? p1_width : p0_width;
        sel_write = grant_port ? p1_write : p0_write;
    end

    mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  ((state_reg == S_IDLE) && grant_valid),
        .enable (state_reg == S_BUSY),
        .expire (wd_expire)
    );

    // ok/err are raised on entry to DONE so they are high for exactly the DONE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            port_reg       <= 1'b0;
            write_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            mem_width      <= '0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            p0_ok          <= 1'b0;
            p0_err         <= 1'b0;
            p0_rdata       <= '0;
            p1_ok          <= 1'b0;
            p1_err         <= 1'b0;
            p1_rdata       <= '0;
        end else begin
            p0_ok  <= 1'b0;
            p0_err <= 1'b0;
            p1_ok  <= 1'b0;
            p1_err <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (grant_valid) begin
                        port_reg  <= grant_port;
                        write_reg <= sel_write;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        mem_width <= sel_width;
                        if (sel_width == W_ILLEGAL) begin
                            state_reg <= S_DONE;
                            if (grant_port) begin
                                p1_ok  <= 1'b1;
                                p1_err <= 1'b1;
                            end else begin
                                p0_ok  <= 1'b1;
                                p0_err <= 1'b1;
                            end
                        end else begin
                            state_reg <= S_BUSY;
                            mem_read  <= ~sel_write;
                            mem_write <= sel_write;
                        end
                    end
                end
                S_BUSY: begin
                    if (mem_ok) begin
                        state_reg <= S_DONE;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        if (port_reg) begin
                            p1_ok <= 1'b1;
                            if (!write_reg) p1_rdata <= mem_rdata;
                        end else begin
                            p0_ok <= 1'b1;
                            if (!write_reg) p0_rdata <= mem_rdata;
                        end
                    end else if (wd_expire) begin
                        state_reg <= S_DONE;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        if (port_reg) begin
                            p1_ok    <= 1'b1;
                            p1_err   <= 1'b1;
                            p1_rdata <= '0;
                        end else begin
                            p0_ok    <= 1'b1;
                            p0_err   <= 1'b1;
                            p0_rdata <= '0;
                        end
                    end
                end
                S_DONE: begin
                    last_grant_reg <= port_reg;
                    state_reg      <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of single transactions plus
// hand-written contention, timeout and reset sequences.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          p0_req = 1'b0, p1_req = 1'b0;
    logic [AW-1:0] p0_addr = '0, p1_addr = '0;
    logic [31:0]   p0_wdata = '0, p1_wdata = '0;
    logic [1:0]    p0_width = '0, p1_width = '0;
    logic          p0_write = 1'b0, p1_write = 1'b0;
    logic          p0_ok, p1_ok, p0_err, p1_err;
    logic [31:0]   p0_rdata, p1_rdata;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [1:0]    mem_width;
    logic          mem_read, mem_write;
    logic [31:0]   mem_rdata = '0;
    logic          mem_ok = 1'b0;

    mem_arbiter #(.TIMEOUT(TO), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_width(p0_width),
        .p0_write(p0_write), .p0_ok(p0_ok), .p0_err(p0_err), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_width(p1_width),
        .p1_write(p1_write), .p1_ok(p1_ok), .p1_err(p1_err), .p1_rdata(p1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_width(mem_width),
        .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata), .mem_ok(mem_ok)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        port;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  width;
        logic        write;
        int          lat;       // memory acks in this BUSY cycle; 0 = never
        logic [31:0] mrd;
        logic        exp_err;
        logic        chk_rd;
        logic [31:0] exp_rd;
        int          exp_strobe;
        int          exp_okc;
    } vec_t;

    vec_t vecs[7];

    function automatic vec_t mk(input logic port, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [1:0] width, input logic write, input int lat,
                                input logic [31:0] mrd, input logic exp_err, input logic chk_rd,
                                input logic [31:0] exp_rd, input int exp_strobe, input int exp_okc);
        vec_t v;
        v.port = port; v.addr = addr; v.wdata = wdata; v.width = width; v.write = write;
        v.lat = lat; v.mrd = mrd; v.exp_err = exp_err; v.chk_rd = chk_rd; v.exp_rd = exp_rd;
        v.exp_strobe = exp_strobe; v.exp_okc = exp_okc;
        return v;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic drive_port(input logic port, input logic req, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [1:0] width, input logic write);
        if (port) begin
            p1_req = req; p1_addr = addr; p1_wdata = wdata; p1_width = width; p1_write = write;
        end else begin
            p0_req = req; p0_addr = addr; p0_wdata = wdata; p0_width = width; p0_write = write;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; p0_req = 1'b0; p1_req = 1'b0; mem_ok = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Entered and left on a negedge with the arbiter idle.
    task automatic run_txn(input int idx, input vec_t v);
        int          strobes = 0;
        int          okc = -1;
        int          dbl = 0;
        int          bad = 0;
        logic        got = 1'b0;
        logic        okport = 1'b0;
        logic        err_s = 1'b0;
        logic [31:0] rd_s = '0;
        logic        strobe;
        drive_port(v.port, 1'b1, v.addr, v.wdata, v.width, v.write);
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            strobe = mem_read | mem_write;
            if (strobe) begin
                strobes++;
                if (mem_addr !== v.addr || mem_write !== v.write || mem_read !== ~v.write ||
                    mem_width !== v.width || (v.write && mem_wdata !== v.wdata))
                    bad++;
            end
            mem_ok    = strobe && (strobes == v.lat);
            mem_rdata = mem_ok ? v.mrd : 32'h0BAD_0BAD;
            if (p0_ok && p1_ok) dbl++;
            if (p0_ok || p1_ok) begin
                got    = 1'b1;
                okc    = c;
                okport = p1_ok;
                err_s  = p1_ok ? p1_err : p0_err;
                rd_s   = p1_ok ? p1_rdata : p0_rdata;
                drive_port(v.port, 1'b0, v.addr, v.wdata, v.width, v.write);
            end
        end
        mem_ok = 1'b0;
        check1("ok_seen", got, 1'b1);
        if (!got) drive_port(v.port, 1'b0, v.addr, v.wdata, v.width, v.write);
        @(negedge clk);
        check1("ok_one_cycle", p0_ok | p1_ok, 1'b0);
        check1("ok_port", okport, v.port);
        check32("ok_cycle", 32'(okc), 32'(v.exp_okc));
        check1("err", err_s, v.exp_err);
        if (v.chk_rd) check32("rdata", rd_s, v.exp_rd);
        check32("strobe_cycles", 32'(strobes), 32'(v.exp_strobe));
        check32("mem_fields_bad", 32'(bad), 32'd0);
        check32("double_ok", 32'(dbl), 32'd0);
        $display("txn %0d port=%0d addr=0x%08h w=%0d wr=%0b ok@%0d err=%0b rdata=0x%08h strobes=%0d",
                 idx, v.port, v.addr, v.width, v.write, okc, err_s, rd_s, strobes);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int          n_ok;
        int          n_addr;
        int          order[2];
        logic [31:0] addr_seq[2];
        int          grants[6];
        int          exp_g[6];
        int          dbl;
        logic        strobe;
        logic        prev_strobe;
        logic        seen;
        int          first_port;

        vecs[0] = mk(1'b0, 32'h0000_0100, 32'h0,          2'd2, 1'b0, 2, 32'hCAFE_F00D, 1'b0, 1'b1, 32'hCAFE_F00D, 2, 2);
        vecs[1] = mk(1'b1, 32'h0000_0200, 32'h0,          2'd1, 1'b0, 1, 32'h1234_5678, 1'b0, 1'b1, 32'h1234_5678, 1, 1);
        vecs[2] = mk(1'b0, 32'h0000_0104, 32'hDEAD_BEEF,  2'd2, 1'b1, 3, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'hCAFE_F00D, 3, 3);
        vecs[3] = mk(1'b1, 32'h0000_0208, 32'h0,          2'd3, 1'b0, 1, 32'h0,         1'b1, 1'b0, 32'h0,         0, 0);
        vecs[4] = mk(1'b1, 32'h0000_020C, 32'h0,          2'd2, 1'b0, 4, 32'hA5A5_0F0F, 1'b0, 1'b1, 32'hA5A5_0F0F, 4, 4);
        vecs[5] = mk(1'b1, 32'h0000_0210, 32'h0000_00AB,  2'd0, 1'b1, 1, 32'h0,         1'b0, 1'b1, 32'hA5A5_0F0F, 1, 1);
        vecs[6] = mk(1'b0, 32'h0000_0108, 32'h0,          2'd2, 1'b0, 0, 32'h0,         1'b1, 1'b1, 32'h0,         4, 4);

        // Reset state
        @(negedge clk);
        check1("rst_mem_read", mem_read, 1'b0);
        check1("rst_mem_write", mem_write, 1'b0);
        check1("rst_p0_ok", p0_ok, 1'b0);
        check1("rst_p1_ok", p1_ok, 1'b0);
        check32("rst_mem_addr", mem_addr, 32'h0);
        check32("rst_p0_rdata", p0_rdata, 32'h0);
        check32("rst_p1_rdata", p1_rdata, 32'h0);
        do_reset();

        for (int i = 0; i < 7; i++) run_txn(i, vecs[i]);

        // Late mem_ok while idle must be ignored.
        mem_ok = 1'b1; mem_rdata = 32'h7777_7777;
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            mem_ok = 1'b0;
            if (p0_ok || p1_ok || mem_read || mem_write) seen = 1'b1;
        end
        check1("late_mem_ok_ignored", seen, 1'b0);
        check32("late_p0_rdata", p0_rdata, 32'h0);
        check32("late_p1_rdata", p1_rdata, 32'hA5A5_0F0F);
        $display("txn late_mem_ok activity=%0b p0_rdata=0x%08h", seen, p0_rdata);

        // Simultaneous requests: p0 write, p1 read.
        do_reset();
`ifdef MEM_ARB_ROUND_ROBIN_EN
        first_port = 0;
`else
        first_port = 1;
`endif
        drive_port(1'b0, 1'b1, 32'h0000_0300, 32'h1111_2222, 2'd2, 1'b1);
        drive_port(1'b1, 1'b1, 32'h0000_0400, 32'h0,         2'd2, 1'b0);
        n_ok = 0; n_addr = 0; dbl = 0; prev_strobe = 1'b0;
        order[0] = -1; order[1] = -1; addr_seq[0] = '0; addr_seq[1] = '0;
        for (int c = 0; c < 60 && n_ok < 2; c++) begin
            @(negedge clk);
            strobe = mem_read | mem_write;
            if (strobe && !prev_strobe && n_addr < 2) begin
                addr_seq[n_addr] = mem_addr;
                n_addr++;
            end
            mem_ok = strobe;
            mem_rdata = 32'h5555_AAAA;
            if (p0_ok && p1_ok) dbl++;
            if (p0_ok) begin
                order[n_ok] = 0; n_ok++; p0_req = 1'b0;
            end else if (p1_ok) begin
                order[n_ok] = 1; n_ok++; p1_req = 1'b0;
            end
            prev_strobe = strobe;
        end
        mem_ok = 1'b0; p0_req = 1'b0; p1_req = 1'b0;
        @(negedge clk);
        check32("sim_ok_count", 32'(n_ok), 32'd2);
        check32("sim_first", 32'(order[0]), 32'(first_port));
        check32("sim_second", 32'(order[1]), 32'(1 - first_port));
        check32("sim_addr0", addr_seq[0], first_port == 0 ? 32'h0000_0300 : 32'h0000_0400);
        check32("sim_addr1", addr_seq[1], first_port == 0 ? 32'h0000_0400 : 32'h0000_0300);
        check32("sim_double_ok", 32'(dbl), 32'd0);
        check32("sim_p1_rdata", p1_rdata, 32'h5555_AAAA);
        check32("sim_p0_rdata", p0_rdata, 32'h0);
        $display("txn simultaneous order=%0d,%0d addrs=0x%08h,0x%08h", order[0], order[1], addr_seq[0], addr_seq[1]);

        // Sustained contention over six transactions.
        do_reset();
        for (int i = 0; i < 6; i++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp_g[i] = i % 2;
`else
            exp_g[i] = 1;
`endif
            grants[i] = -1;
        end
        drive_port(1'b0, 1'b1, 32'h0000_0500, 32'h0, 2'd2, 1'b0);
        drive_port(1'b1, 1'b1, 32'h0000_0600, 32'h0, 2'd2, 1'b0);
        n_ok = 0; dbl = 0;
        for (int c = 0; c < 100 && n_ok < 6; c++) begin
            @(negedge clk);
            mem_ok = mem_read | mem_write;
            mem_rdata = 32'h0000_0600;
            if (p0_ok && p1_ok) dbl++;
            if (p0_ok || p1_ok) begin
                grants[n_ok] = p1_ok ? 1 : 0;
                n_ok++;
            end
            if (n_ok == 6) begin
                p0_req = 1'b0; p1_req = 1'b0;
            end
        end
        mem_ok = 1'b0; p0_req = 1'b0; p1_req = 1'b0;
        @(negedge clk);
        check32("sus_ok_count", 32'(n_ok), 32'd6);
        check32("sus_double_ok", 32'(dbl), 32'd0);
        for (int i = 0; i < 6; i++) check32($sformatf("sus_grant%0d", i), 32'(grants[i]), 32'(exp_g[i]));
        $display("txn sustained grants=%0d,%0d,%0d,%0d,%0d,%0d",
                 grants[0], grants[1], grants[2], grants[3], grants[4], grants[5]);

        // Reset during BUSY.
        drive_port(1'b0, 1'b1, 32'h0000_0700, 32'h0, 2'd2, 1'b0);
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (mem_read) seen = 1'b1;
        end
        check1("rstmid_busy_reached", seen, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check1("rstmid_read_async", mem_read, 1'b0);
        check1("rstmid_ok_async", p0_ok, 1'b0);
        p0_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (p0_ok || p1_ok || mem_read || mem_write) seen = 1'b1;
        end
        check1("rstmid_no_ack", seen, 1'b0);
        $display("txn reset_mid_access activity_after=%0b", seen);
        run_txn(7, mk(1'b0, 32'h0000_0704, 32'h0, 2'd2, 1'b0, 2, 32'h0BEE_F123, 1'b0, 1'b1, 32'h0BEE_F123, 2, 2));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
